// File: rtl/bit_scan_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_scan_pkg
// Description : Shared types and helpers for the bit_scan_encoder block:
//               scan state encoding and a population-count function.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_scan_pkg;

   // Two-state scan controller, explicit one-bit encoding
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Widest request vector the popcount helper handles; callers zero-extend
   // their N-bit vector to this width so one function serves every N.
   localparam int C_POP_MAX_W = 256;

   function automatic int unsigned popcount(input logic [C_POP_MAX_W-1:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < C_POP_MAX_W; i++) begin
         c = c + 32'(v[i]);
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_scan_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_scan_encoder_if
// Description : Request-in / index-out handshake bundle of bit_scan_encoder.
//               slave = the encoder, master = upstream producer plus
//               downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_scan_encoder_if #(
   parameter int N = 8
);
   localparam int W = $clog2(N);

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_vec;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_idx;
   logic          out_last;
   logic          out_none;
   logic [W:0]    out_cnt;

   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_idx, out_last, out_none, out_cnt
   );

   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_idx, out_last, out_none, out_cnt
   );

endinterface
`default_nettype wire

// File: rtl/bit_scan_encoder_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc
// Description : Combinational N-input priority encoder. Reports the index of
//               the winning set bit, whether any bit is set, and a one-hot
//               mask of the winner. idx is 0 when nothing is set.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b0,
   localparam int W        = $clog2(N)
) (
   input  wire logic [N-1:0] vec,
   output logic      [W-1:0] idx,
   output logic              found,
   output logic      [N-1:0] onehot_sel
);

   generate
      if (MSB_FIRST) begin : g_msb_first
         // Scan upward so the highest set bit is the last one written
         always_comb begin
            idx        = '0;
            found      = 1'b0;
            onehot_sel = '0;
            for (int i = 0; i < N; i++) begin
               if (vec[i]) begin
                  idx        = W'(i);
                  found      = 1'b1;
                  onehot_sel = '0;
                  onehot_sel[i] = 1'b1;
               end
            end
         end
      end else begin : g_lsb_first
         // Scan downward so the lowest set bit is the last one written
         always_comb begin
            idx        = '0;
            found      = 1'b0;
            onehot_sel = '0;
            for (int i = N - 1; i >= 0; i--) begin
               if (vec[i]) begin
                  idx        = W'(i);
                  found      = 1'b1;
                  onehot_sel = '0;
                  onehot_sel[i] = 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/bit_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bit_scan_encoder
// Description : Accepts an N-bit request vector and emits the binary index of
//               each set bit, one beat per bit, in fixed priority order. An
//               all-zero vector produces a single out_none beat. A new vector
//               can be taken on the final beat of the previous one, so
//               consecutive vectors stream without a bubble.
//               Note: in_ready depends combinationally on out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_scan_encoder
   import bit_scan_pkg::*;
#(
   parameter int N         = 8,   // must match the interface parameter
   parameter bit MSB_FIRST = 1'b0,
   localparam int W        = $clog2(N)
) (
   input  wire logic            clk,
   input  wire logic            rst,
   bit_scan_encoder_if.slave    bus
);

   state_t              r_state, w_state_nxt;
   logic [N-1:0]        r_vec,   w_vec_nxt;
   logic [W:0]          r_cnt,   w_cnt_nxt;
   logic                r_none,  w_none_nxt;

   logic [W-1:0]        w_idx;
   logic                w_found;
   logic [N-1:0]        w_sel;
   logic                w_single;
   logic                w_last;
   logic                w_out_valid;
   logic                w_in_ready;
   logic                w_accept;
   logic                w_beat;
   logic [C_POP_MAX_W-1:0] w_ext;
   logic [W:0]          w_cnt_in;

   prio_enc #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_prio_enc (
      .vec        (r_vec),
      .idx        (w_idx),
      .found      (w_found),
      .onehot_sel (w_sel)
   );

   // Zero-extend the incoming vector for the shared popcount helper
   always_comb begin
      w_ext        = '0;
      w_ext[N-1:0] = bus.in_vec;
      w_cnt_in     = (W+1)'(popcount(w_ext));
   end

   assign w_single    = w_found && ((r_vec & (r_vec - N'(1))) == '0);
   assign w_last      = w_single || r_none;
   assign w_out_valid = !rst && (r_state == SCAN);
   assign w_in_ready  = !rst && ((r_state == IDLE) ||
                                 ((r_state == SCAN) && w_last && bus.out_ready));
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_beat      = w_out_valid && bus.out_ready;

   assign bus.out_valid = w_out_valid;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_idx   = w_idx;
   assign bus.out_last  = w_last;
   assign bus.out_none  = r_none;
   assign bus.out_cnt   = r_cnt;

   // Next-state logic: retire the current bit on a beat; a new acceptance
   // (possible on the final beat) overrides and keeps the FSM in SCAN
   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_cnt_nxt   = r_cnt;
      w_none_nxt  = r_none;
      if (w_beat) begin
         w_vec_nxt = r_vec & ~w_sel;
         if (w_last) begin
            w_state_nxt = IDLE;
         end
      end
      if (w_accept) begin
         w_vec_nxt   = bus.in_vec;
         w_cnt_nxt   = w_cnt_in;
         w_none_nxt  = (bus.in_vec == '0);
         w_state_nxt = SCAN;
      end
   end

   // State and scan registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_vec   <= '0;
         r_cnt   <= '0;
         r_none  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_cnt   <= w_cnt_nxt;
         r_none  <= w_none_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bit_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_scan_encoder
// Description : Directed self-checking bench for bit_scan_encoder. Three
//               instances: N=8 LSB-first, N=8 MSB-first, N=16 LSB-first.
//               Inputs change and outputs are sampled around the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_scan_encoder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   bit_scan_encoder_if #(.N(8))  ifa ();
   bit_scan_encoder_if #(.N(8))  ifb ();
   bit_scan_encoder_if #(.N(16)) ifc ();

   bit_scan_encoder #(.N(8),  .MSB_FIRST(1'b0)) u_dut_lsb   (.clk(clk), .rst(rst), .bus(ifa));
   bit_scan_encoder #(.N(8),  .MSB_FIRST(1'b1)) u_dut_msb   (.clk(clk), .rst(rst), .bus(ifb));
   bit_scan_encoder #(.N(16), .MSB_FIRST(1'b0)) u_dut_wide  (.clk(clk), .rst(rst), .bus(ifc));

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset();
      rst = 1'b1;
      ifa.in_valid = 1'b1; ifa.in_vec = 8'hAA; ifa.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", c, ifa.in_ready); end
         checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, ifa.out_valid); end
      end
      @(negedge clk);
      rst = 1'b0; ifa.in_valid = 1'b0;
      #1;
      checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", ifa.in_ready); end
      checks++; if (ifa.out_cnt !== 4'd0) begin errors++; $display("FAIL post_reset_out_cnt: got %0d want 0", ifa.out_cnt); end
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", ifa.out_valid); end
      checks++; if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_msb_in_ready: got %b want 1", ifb.in_ready); end
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wide_in_ready: got %b want 1", ifc.in_ready); end
   endtask

   task automatic test_lsb_scan();
      int unsigned exp_idx [4];
      exp_idx[0] = 1; exp_idx[1] = 2; exp_idx[2] = 5; exp_idx[3] = 7;
      @(negedge clk);
      ifa.in_vec = 8'b1010_0110; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
      #1;
      checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL lsb_accept_ready: got %b want 1", ifa.in_ready); end
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         ifa.in_valid = 1'b0;
         #1;
         checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid beat%0d: got %b want 1", b, ifa.out_valid); end
         checks++; if (ifa.out_idx !== 3'(exp_idx[b])) begin errors++; $display("FAIL lsb_idx beat%0d: got %0d want %0d", b, ifa.out_idx, exp_idx[b]); end
         checks++; if (ifa.out_last !== (b == 3)) begin errors++; $display("FAIL lsb_last beat%0d: got %b want %b", b, ifa.out_last, (b == 3)); end
         checks++; if (ifa.out_cnt !== 4'd4) begin errors++; $display("FAIL lsb_cnt beat%0d: got %0d want 4", b, ifa.out_cnt); end
         checks++; if (ifa.in_ready !== (b == 3)) begin errors++; $display("FAIL lsb_in_ready beat%0d: got %b want %b", b, ifa.in_ready, (b == 3)); end
      end
      @(negedge clk); #1;
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL lsb_done_valid: got %b want 0", ifa.out_valid); end
   endtask

   task automatic test_msb_scan();
      int unsigned exp_idx [4];
      exp_idx[0] = 7; exp_idx[1] = 5; exp_idx[2] = 2; exp_idx[3] = 1;
      @(negedge clk);
      ifb.in_vec = 8'b1010_0110; ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         ifb.in_valid = 1'b0;
         #1;
         checks++; if (ifb.out_valid !== 1'b1) begin errors++; $display("FAIL msb_valid beat%0d: got %b want 1", b, ifb.out_valid); end
         checks++; if (ifb.out_idx !== 3'(exp_idx[b])) begin errors++; $display("FAIL msb_idx beat%0d: got %0d want %0d", b, ifb.out_idx, exp_idx[b]); end
         checks++; if (ifb.out_last !== (b == 3)) begin errors++; $display("FAIL msb_last beat%0d: got %b want %b", b, ifb.out_last, (b == 3)); end
         checks++; if (ifb.out_cnt !== 4'd4) begin errors++; $display("FAIL msb_cnt beat%0d: got %0d want 4", b, ifb.out_cnt); end
      end
      @(negedge clk); #1;
      checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL msb_done_valid: got %b want 0", ifb.out_valid); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      ifa.in_vec = 8'h81; ifa.in_valid = 1'b1; ifa.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         ifa.in_vec    = (c % 2 == 0) ? 8'h3C : 8'hC3;
         ifa.in_valid  = 1'b1;
         ifa.out_ready = (c == 4);
         #1;
         checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d: got %b want 1", c, ifa.out_valid); end
         checks++; if (ifa.out_idx !== 3'd0) begin errors++; $display("FAIL bp_idx_hold cyc%0d: got %0d want 0", c, ifa.out_idx); end
         checks++; if (ifa.out_last !== 1'b0) begin errors++; $display("FAIL bp_last cyc%0d: got %b want 0", c, ifa.out_last); end
         checks++; if (ifa.out_cnt !== 4'd2) begin errors++; $display("FAIL bp_cnt cyc%0d: got %0d want 2", c, ifa.out_cnt); end
         checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", c, ifa.in_ready); end
      end
      @(negedge clk);
      ifa.in_valid = 1'b0;
      #1;
      checks++; if (ifa.out_idx !== 3'd7) begin errors++; $display("FAIL bp_second_idx: got %0d want 7", ifa.out_idx); end
      checks++; if (ifa.out_last !== 1'b1) begin errors++; $display("FAIL bp_second_last: got %b want 1", ifa.out_last); end
      checks++; if (ifa.out_cnt !== 4'd2) begin errors++; $display("FAIL bp_second_cnt: got %0d want 2", ifa.out_cnt); end
      @(negedge clk); #1;
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid: got %b want 0", ifa.out_valid); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ifa.in_vec = 8'h00; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
      @(negedge clk);
      ifa.in_vec = 8'hFF; ifa.in_valid = 1'b1;
      #1;
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL empty_valid: got %b want 1", ifa.out_valid); end
      checks++; if (ifa.out_none !== 1'b1) begin errors++; $display("FAIL empty_none: got %b want 1", ifa.out_none); end
      checks++; if (ifa.out_last !== 1'b1) begin errors++; $display("FAIL empty_last: got %b want 1", ifa.out_last); end
      checks++; if (ifa.out_idx !== 3'd0) begin errors++; $display("FAIL empty_idx: got %0d want 0", ifa.out_idx); end
      checks++; if (ifa.out_cnt !== 4'd0) begin errors++; $display("FAIL empty_cnt: got %0d want 0", ifa.out_cnt); end
      checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL empty_in_ready: got %b want 1", ifa.in_ready); end
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         ifa.in_valid = 1'b0;
         #1;
         checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL full_valid beat%0d: got %b want 1", b, ifa.out_valid); end
         checks++; if (ifa.out_idx !== 3'(b)) begin errors++; $display("FAIL full_idx beat%0d: got %0d want %0d", b, ifa.out_idx, b); end
         checks++; if (ifa.out_last !== (b == 7)) begin errors++; $display("FAIL full_last beat%0d: got %b want %b", b, ifa.out_last, (b == 7)); end
         checks++; if (ifa.out_none !== 1'b0) begin errors++; $display("FAIL full_none beat%0d: got %b want 0", b, ifa.out_none); end
         checks++; if (ifa.out_cnt !== 4'd8) begin errors++; $display("FAIL full_cnt beat%0d: got %0d want 8", b, ifa.out_cnt); end
      end
      @(negedge clk); #1;
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL full_done_valid: got %b want 0", ifa.out_valid); end
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      ifc.in_vec = 16'h8001; ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      #1;
      checks++; if (ifc.out_idx !== 4'd0) begin errors++; $display("FAIL wide_first_idx: got %0d want 0", ifc.out_idx); end
      checks++; if (ifc.out_cnt !== 5'd2) begin errors++; $display("FAIL wide_first_cnt: got %0d want 2", ifc.out_cnt); end
      checks++; if (ifc.out_last !== 1'b0) begin errors++; $display("FAIL wide_first_last: got %b want 0", ifc.out_last); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL wide_rst_valid: got %b want 0", ifc.out_valid); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL wide_post_rst_valid: got %b want 0", ifc.out_valid); end
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL wide_post_rst_ready: got %b want 1", ifc.in_ready); end
      checks++; if (ifc.out_cnt !== 5'd0) begin errors++; $display("FAIL wide_post_rst_cnt: got %0d want 0", ifc.out_cnt); end
      @(negedge clk); #1;
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL wide_no_idx15_beat: got valid %b idx %0d want no beat", ifc.out_valid, ifc.out_idx); end
      ifc.in_vec = 16'h4000; ifc.in_valid = 1'b1;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      #1;
      checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL wide_single_valid: got %b want 1", ifc.out_valid); end
      checks++; if (ifc.out_idx !== 4'd14) begin errors++; $display("FAIL wide_single_idx: got %0d want 14", ifc.out_idx); end
      checks++; if (ifc.out_last !== 1'b1) begin errors++; $display("FAIL wide_single_last: got %b want 1", ifc.out_last); end
      checks++; if (ifc.out_cnt !== 5'd1) begin errors++; $display("FAIL wide_single_cnt: got %0d want 1", ifc.out_cnt); end
      @(negedge clk); #1;
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL wide_done_valid: got %b want 0", ifc.out_valid); end
   endtask

   // Test sequence
   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      ifa.in_valid = 1'b0; ifa.in_vec = '0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_vec = '0; ifb.out_ready = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_vec = '0; ifc.out_ready = 1'b0;
      test_reset();
      test_lsb_scan();
      test_msb_scan();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
